// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - FND font codes, frame constants, FSM states and select helpers.
package fnd_pkg;

  localparam int FND_DIGITS = 4;

  localparam logic [7:0] FONT_0    = 8'hc0;
  localparam logic [7:0] FONT_1    = 8'hf9;
  localparam logic [7:0] FONT_2    = 8'ha4;
  localparam logic [7:0] FONT_3    = 8'hb0;
  localparam logic [7:0] FONT_4    = 8'h99;
  localparam logic [7:0] FONT_5    = 8'h92;
  localparam logic [7:0] FONT_6    = 8'h82;
  localparam logic [7:0] FONT_7    = 8'hf8;
  localparam logic [7:0] FONT_8    = 8'h80;
  localparam logic [7:0] FONT_9    = 8'h98;
  localparam logic [7:0] FONT_DARK = 8'h00;

  localparam logic [3:0] NIBBLE_INVALID = 4'hF;

  typedef enum logic [1:0] {
    FND_IDLE   = 2'd0,
    FND_SETTLE = 2'd1,
    FND_HELD   = 2'd2
  } fnd_state_e;

  // Exactly one select line pulled low.
  function automatic logic sel_onehot(input logic [3:0] sel);
    return $countones(~sel) == 1;
  endfunction

  function automatic logic [1:0] sel_index(input logic [3:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!sel[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fnd_font_to_bcd.sv
// rtl/fnd_font_to_bcd.sv - Combinational font to BCD decode; FND_READER_DP_EN ignores the dp bit in the match.
module fnd_font_to_bcd
  import fnd_pkg::*;
(
  input  logic [7:0] font,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err,
  output logic       dp
);

  logic [7:0] key;

  always_comb begin
    nibble = NIBBLE_INVALID;
    blank  = 1'b0;
    err    = 1'b0;
`ifdef FND_READER_DP_EN
    // Every table entry has bit 7 set, so forcing it lets a lit dp still match.
    key = {1'b1, font[6:0]};
    dp  = ~font[7];
`else
    key = font;
    dp  = 1'b0;
`endif
    if (font == FONT_DARK) begin
      blank = 1'b1;
    end else begin
      case (key)
        FONT_0:  nibble = 4'd0;
        FONT_1:  nibble = 4'd1;
        FONT_2:  nibble = 4'd2;
        FONT_3:  nibble = 4'd3;
        FONT_4:  nibble = 4'd4;
        FONT_5:  nibble = 4'd5;
        FONT_6:  nibble = 4'd6;
        FONT_7:  nibble = 4'd7;
        FONT_8:  nibble = 4'd8;
        FONT_9:  nibble = 4'd9;
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_reader.sv
// rtl/fnd_scan_reader.sv - FND bus monitor: debounces each digit dwell, decodes fonts, publishes 4-digit frames.
// Optional build macro FND_READER_DP_EN enables decimal-point reporting on o_dp.
module fnd_scan_reader
  import fnd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = FND_DIGITS
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DIGITS-1:0]     i_digit_sel,
  input  logic [7:0]            i_font,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_blank,
  output logic [DIGITS-1:0]     o_err,
  output logic [DIGITS-1:0]     o_dp,
  output logic                  o_frame_valid,
  output logic                  o_valid
);

  logic [DIGITS-1:0]   sel_q, prev_sel;
  logic [7:0]          font_q, prev_font;
  fnd_state_e          state, state_n;
  logic [7:0]          cnt, cnt_n;
  logic                capture;
  logic                same;
  logic                onehot;
  logic [1:0]          idx;
  logic [DIGITS-1:0]   mask;
  logic [4*DIGITS-1:0] sh_bcd;
  logic [DIGITS-1:0]   sh_blank, sh_err, sh_dp;
  logic [3:0]          dec_nib;
  logic                dec_blank, dec_err, dec_dp;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sel_q     <= '1;
      font_q    <= '1;
      prev_sel  <= '1;
      prev_font <= '1;
    end else begin
      sel_q     <= i_digit_sel;
      font_q    <= i_font;
      prev_sel  <= sel_q;
      prev_font <= font_q;
    end
  end

  assign same   = (sel_q == prev_sel) && (font_q == prev_font);
  assign onehot = sel_onehot(sel_q);
  assign idx    = sel_index(sel_q);

  fnd_font_to_bcd u_dec (
    .font   (font_q),
    .nibble (dec_nib),
    .blank  (dec_blank),
    .err    (dec_err),
    .dp     (dec_dp)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      FND_IDLE: begin
        if (onehot) begin
          state_n = FND_SETTLE;
          cnt_n   = 8'd1;
        end else begin
          cnt_n = 8'd0;
        end
      end
      FND_SETTLE, FND_HELD: begin
        if (!same) begin
          if (onehot) begin
            state_n = FND_SETTLE;
            cnt_n   = 8'd1;
          end else begin
            state_n = FND_IDLE;
            cnt_n   = 8'd0;
          end
        end else if (state == FND_SETTLE) begin
          if (cnt == 8'(STABLE_CYCLES - 1)) begin
            capture = 1'b1;
            state_n = FND_HELD;
            cnt_n   = 8'(STABLE_CYCLES);
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      default: begin
        state_n = FND_IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= FND_IDLE;
      cnt           <= 8'd0;
      mask          <= '0;
      sh_bcd        <= '1;
      sh_blank      <= '0;
      sh_err        <= '0;
      sh_dp         <= '0;
      o_bcd         <= '1;
      o_blank       <= '0;
      o_err         <= '0;
      o_dp          <= '0;
      o_frame_valid <= 1'b0;
      o_valid       <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      o_frame_valid <= 1'b0;
      if (capture) begin
        sh_bcd[{idx, 2'b00} +: 4] <= dec_nib;
        sh_blank[idx]             <= dec_blank;
        sh_err[idx]               <= dec_err;
        sh_dp[idx]                <= dec_dp;
      end
      // Publish copies the pre-capture shadow; a same-edge capture seeds the next frame.
      if (&mask) begin
        o_bcd         <= sh_bcd;
        o_blank       <= sh_blank;
        o_err         <= sh_err;
        o_dp          <= sh_dp;
        o_frame_valid <= 1'b1;
        o_valid       <= 1'b1;
        mask          <= capture ? ~sel_q : '0;
      end else if (capture) begin
        mask <= mask | ~sel_q;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_reader.sv
// tb/tb_fnd_scan_reader.sv - Scoreboard bench for fnd_scan_reader with a run-length reference model.
module tb_fnd_scan_reader;

  localparam int S = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [3:0]  i_digit_sel = 4'hF;
  logic [7:0]  i_font = 8'hFF;
  logic [15:0] o_bcd;
  logic [3:0]  o_blank, o_err, o_dp;
  logic        o_frame_valid, o_valid;

  fnd_scan_reader #(.STABLE_CYCLES(S), .DIGITS(4)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_digit_sel   (i_digit_sel),
    .i_font        (i_font),
    .o_bcd         (o_bcd),
    .o_blank       (o_blank),
    .o_err         (o_err),
    .o_dp          (o_dp),
    .o_frame_valid (o_frame_valid),
    .o_valid       (o_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic [3:0]  dp;
    int          cyc;
  } frame_t;

  frame_t      sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          frames = 0;
  logic        prev_fv = 1'b0;
  logic [7:0]  font_tbl [10];

  // Expected steady output state between frames.
  logic [15:0] h_bcd = 16'hFFFF;
  logic [3:0]  h_blank = 4'h0, h_err = 4'h0, h_dp = 4'h0;
  logic        h_valid = 1'b0;

  // Reference model state.
  logic [3:0]  run_sel;
  logic [7:0]  run_font;
  int          run_len = 0;
  logic [15:0] m_bcd = 16'hFFFF;
  logic [3:0]  m_blank = 4'h0, m_err = 4'h0, m_dp = 4'h0, m_mask = 4'h0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ref_decode(input logic [7:0] f, output logic [3:0] nib,
                            output logic bl, output logic er, output logic d);
    logic [7:0] t;
    nib = 4'hF;
    bl  = 1'b0;
    er  = 1'b0;
    d   = 1'b0;
`ifdef FND_READER_DP_EN
    d = ~f[7];
`endif
    if (f == 8'h00) begin
      bl = 1'b1;
    end else begin
      er = 1'b1;
      for (int i = 0; i < 10; i++) begin
        t = font_tbl[i];
`ifdef FND_READER_DP_EN
        if (t[6:0] == f[6:0]) begin
`else
        if (t == f) begin
`endif
          nib = 4'(i);
          er  = 1'b0;
        end
      end
    end
  endtask

  task automatic model_capture(input logic [3:0] s, input logic [7:0] f, input int k);
    int d;
    logic [3:0] nib;
    logic bl, er, dpv;
    frame_t e;
    d = 0;
    for (int i = 0; i < 4; i++) if (!s[i]) d = i;
    ref_decode(f, nib, bl, er, dpv);
    m_bcd[4*d +: 4] = nib;
    m_blank[d] = bl;
    m_err[d]   = er;
    m_dp[d]    = dpv;
    m_mask[d]  = 1'b1;
    if (m_mask == 4'hF) begin
      e.bcd = m_bcd; e.blank = m_blank; e.err = m_err; e.dp = m_dp;
      e.cyc = k + 2;
      sb.push_back(e);
      m_mask = 4'h0;
    end
  endtask

  // One bus cycle: drive, update the run-length model, advance to just past the edge.
  task automatic apply(input logic [3:0] s, input logic [7:0] f);
    int k;
    k = cyc + 1;
    i_digit_sel = s;
    i_font = f;
    if (run_len > 0 && s == run_sel && f == run_font) begin
      run_len++;
    end else begin
      run_sel  = s;
      run_font = f;
      run_len  = 1;
    end
    if (run_len == S && $countones(~s) == 1) model_capture(s, f, k);
    @(posedge i_clk);
    #1;
  endtask

  task automatic dwell(input logic [3:0] s, input logic [7:0] f, input int n);
    repeat (n) apply(s, f);
  endtask

  task automatic scan(input logic [31:0] fonts, input int n);
    dwell(4'he, fonts[7:0], n);
    dwell(4'hd, fonts[15:8], n);
    dwell(4'hb, fonts[23:16], n);
    dwell(4'h7, fonts[31:24], n);
  endtask

  task automatic do_reset(input int n);
    i_reset = 1'b1;
    i_digit_sel = 4'hF;
    i_font = 8'hFF;
    while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    @(posedge i_clk);
    #1;
    h_bcd = 16'hFFFF; h_blank = 4'h0; h_err = 4'h0; h_dp = 4'h0; h_valid = 1'b0;
    chk("reset_bcd", o_bcd, 16'hFFFF);
    chk("reset_blank", o_blank, 4'h0);
    chk("reset_err", o_err, 4'h0);
    chk("reset_dp", o_dp, 4'h0);
    chk("reset_frame_valid", o_frame_valid, 1'b0);
    chk("reset_valid", o_valid, 1'b0);
    repeat (n - 1) begin
      @(posedge i_clk);
      #1;
    end
    i_reset = 1'b0;
    run_len = 0;
    m_bcd = 16'hFFFF; m_blank = 4'h0; m_err = 4'h0; m_dp = 4'h0; m_mask = 4'h0;
  endtask

  always @(negedge i_clk) begin
    frame_t e;
    if (o_frame_valid) begin
      frames++;
      chk("fv_consecutive", prev_fv, 1'b0);
      if (sb.size() == 0) begin
        chk("unexpected_frame", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("frame_bcd", o_bcd, e.bcd);
        chk("frame_blank", o_blank, e.blank);
        chk("frame_err", o_err, e.err);
        chk("frame_dp", o_dp, e.dp);
        chk("frame_cycle", cyc, e.cyc);
        chk("frame_valid_flag", o_valid, 1'b1);
        h_bcd = e.bcd; h_blank = e.blank; h_err = e.err; h_dp = e.dp; h_valid = 1'b1;
      end
    end else begin
      chk("hold_outputs", {o_bcd, o_blank, o_err, o_dp, o_valid},
          {h_bcd, h_blank, h_err, h_dp, h_valid});
    end
    prev_fv = o_frame_valid;
  end

  initial begin
    int f0;
    int seg_sel, seg_font, n;
    logic [3:0] s;
    logic [7:0] f;
    logic [7:0] t;

    font_tbl = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8, 8'h80, 8'h98};
    do_reset(3);

    f0 = frames;
    scan(32'h99b0a4f9, 8);
    dwell(4'hF, 8'hFF, 3);
    chk("scan_frames", frames - f0, 1);
    chk("scan_bcd", o_bcd, 16'h4321);
    chk("scan_err", o_err, 4'h0);
    chk("scan_valid", o_valid, 1'b1);

    f0 = frames;
    dwell(4'hb, 8'hb0, S - 1);
    scan(32'h99b0a4f9, 8);
    dwell(4'hF, 8'hFF, 3);
    chk("short_dwell_frames", frames - f0, 1);

    scan(32'h889200c0, 8);
    dwell(4'hF, 8'hFF, 3);
    chk("blank_err_nibble", o_bcd[7:4], 4'hF);
    chk("blank_mask", o_blank, 4'b0010);
    chk("err_mask", o_err, 4'b1000);

    f0 = frames;
    dwell(4'he, 8'hc0, 8);
    dwell(4'hd, 8'hf9, 8);
    dwell(4'hb, 8'ha4, 8);
    dwell(4'hc, 8'h99, 20);
    chk("twohot_no_frame", frames - f0, 0);
    dwell(4'h7, 8'hb0, 8);
    dwell(4'hF, 8'hFF, 3);
    chk("twohot_then_complete", frames - f0, 1);
    chk("twohot_bcd", o_bcd, 16'h3210);

    scan(32'hb0a4f940, 8);
    dwell(4'hF, 8'hFF, 3);
`ifdef FND_READER_DP_EN
    chk("dp_font_bcd", o_bcd, 16'h3210);
    chk("dp_font_dp", o_dp, 4'b0001);
    chk("dp_font_err", o_err, 4'b0000);
`else
    chk("dp_font_bcd", o_bcd, 16'h321F);
    chk("dp_font_err", o_err, 4'b0001);
    chk("dp_font_dp", o_dp, 4'b0000);
`endif

    dwell(4'he, 8'h99, 8);
    dwell(4'hd, 8'h92, 8);
    dwell(4'hb, 8'h82, 8);
    do_reset(2);
    f0 = frames;
    dwell(4'h7, 8'hf8, 8);
    dwell(4'hF, 8'hFF, 3);
    chk("reset_discard", frames - f0, 0);
    scan(32'h98808292, 8);
    dwell(4'hF, 8'hFF, 3);
    chk("post_reset_frame", frames - f0, 1);

    for (int seg = 0; seg < 400; seg++) begin
      seg_sel = $urandom_range(0, 9);
      if (seg_sel < 7) begin
        s = 4'hF;
        s[$urandom_range(0, 3)] = 1'b0;
      end else if (seg_sel == 7) begin
        s = 4'hF;
      end else begin
        s = 4'($urandom_range(0, 15));
      end
      seg_font = $urandom_range(0, 9);
      t = font_tbl[$urandom_range(0, 9)];
      if (seg_font < 7)       f = t;
      else if (seg_font == 7) f = 8'h00;
      else if (seg_font == 8) f = 8'($urandom_range(0, 255));
      else                    f = {1'b0, t[6:0]};
      n = $urandom_range(1, S + 3);
      dwell(s, f, n);
      if ($urandom_range(0, 59) == 0) do_reset(2);
    end
    dwell(4'hF, 8'hFF, 6);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
